acc_out_packer: RTL and testbench
=================================

ACC_OUT_PACKER -- requirements
Module: acc_out_packer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving FIFO capacity in 256-bit vectors; legal range 2..15.
REQ-002 SHALL have parameter RELU_EN, default 0; when 1, negative fp16 lanes are zeroed on write.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1, pulse marking one result vector from the temporal accumulator; no backpressure exists on this port.
REQ-006 SHALL have port in_vector, input, 256, sixteen fp16 lanes; lane k occupies bits [16k+15:16k].
REQ-007 SHALL have port out_valid, output, 1, a beat is presented on out_data.
REQ-008 SHALL have port out_ready, input, 1, consumer accepts the beat when out_valid && out_ready.
REQ-009 SHALL have port out_data, output, 64, one beat of four fp16 lanes.
REQ-010 SHALL have port out_last, output, 1, high on the final (4th) beat of a vector.
REQ-011 SHALL have port level, output, 4, number of vectors currently stored.
REQ-012 SHALL have port overflow, output, 1, sticky flag set when an input vector is dropped.
REQ-013 SHALL have port ovf_clr, input, 1, synchronous clear of overflow.

Function
REQ-014 SHALL store accepted vectors in a DEPTH-entry circular FIFO with wrap-around write and read pointers.
REQ-015 SHALL accept a write when in_valid is high and the FIFO is not full, or when it is full and the head's final beat is handed off in the same cycle.
REQ-016 SHALL, with RELU_EN=1, replace any lane whose bit 15 is 1 with 16'h0000 before storage, including -0 and negative NaN; with RELU_EN=0 data is stored unmodified.
REQ-017 SHALL assert out_valid the cycle after a write into an empty FIFO (1-cycle latency), and keep it high while level > 0.
REQ-018 SHALL serialise the head vector in four beats via a 2-bit beat counter: beat n carries bits [64n+63:64n], lanes 4n..4n+3.
REQ-019 SHALL advance the beat counter only on out_valid && out_ready; beat 3 handoff resets the counter to 0 and pops the head.
REQ-020 SHALL hold out_data, out_last and out_valid stable while out_valid is high and out_ready is low.
REQ-021 SHALL drive out_last = out_valid && (beat counter == 3).
REQ-022 SHALL drive out_data to 0 when out_valid is low.
REQ-023 SHALL update level as +1 on write only, -1 on pop only, and unchanged on simultaneous write and pop.
REQ-024 SHALL, on in_valid while full without a same-cycle pop, drop the vector, leave FIFO contents and pointers unchanged, and set overflow.
REQ-025 SHALL clear overflow on ovf_clr; if ovf_clr and a drop coincide, overflow SHALL be set (set wins).
REQ-026 SHALL sustain back-to-back vectors with no idle cycle between beat 3 of one vector and beat 0 of the next when out_ready stays high.

Reset
REQ-027 SHALL, on rst_n low, immediately clear pointers, beat counter, level and overflow, and drive out_valid=0, out_last=0, out_data=0; stored data need not be cleared.
REQ-028 SHALL discard any partially transmitted vector when reset is asserted mid-operation; after release the FIFO is empty.

Verification
REQ-029 Single vector, lanes k=16'h3C00+k, out_ready=1 -> out_valid one cycle later; 4 beats, beat0=64'h3C03_3C02_3C01_3C00; out_last on beat 3 only; level returns to 0.
REQ-030 out_ready low for 5 cycles during beat 1 -> out_data, out_last and out_valid held constant; transfer resumes at beat 1, with no beat lost or repeated.
REQ-031 out_ready=0, six in_valid pulses with DEPTH=4 -> level=4, overflow=1 after the 5th pulse; drain yields vectors 1-4 in order; ovf_clr pulse -> overflow=0.
REQ-032 FIFO full, in_valid coincides with the beat-3 handoff -> write accepted, level stays 4, overflow stays 0.
REQ-033 RELU_EN=1, lanes alternate 16'hC000 / 16'h4000, lane 0 = 16'h8000 -> negative lanes and -0 output as 16'h0000, positive lanes unchanged.
REQ-034 rst_n asserted asynchronously mid-beat 2 with level=3 -> outputs 0 without waiting for a clock edge; after release level=0, out_valid=0, and the next vector starts at beat 0.

Source files
------------

// File: rtl/acc_out_packer.sv
// Output packer for the temporal accumulator: buffers 256-bit result vectors in a
// small circular FIFO and streams each one out as four 64-bit beats.
module acc_out_packer #(
    parameter int DEPTH   = 4,
    parameter int RELU_EN = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [255:0] in_vector,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_data,
    output logic         out_last,
    output logic [3:0]   level,
    output logic         overflow,
    input  logic         ovf_clr
);

    localparam int AW = $clog2(DEPTH);

    function automatic logic [255:0] relu16(input logic [255:0] v);
        logic [255:0] r;
        for (int k = 0; k < 16; k++) begin
            r[16*k +: 16] = v[16*k+15] ? 16'h0000 : v[16*k +: 16];
        end
        return r;
    endfunction

    function automatic logic [63:0] beat_sel(input logic [255:0] v, input logic [1:0] b);
        logic [63:0] r;
        case (b)
            2'd0:    r = v[63:0];
            2'd1:    r = v[127:64];
            2'd2:    r = v[191:128];
            2'd3:    r = v[255:192];
            default: r = 64'h0;
        endcase
        return r;
    endfunction

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? {AW{1'b0}} : p + AW'(1);
    endfunction

    logic [255:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [1:0]    beat_q, beat_d;
    logic [3:0]    level_q, level_d;
    logic          ovf_q, ovf_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic [63:0]   out_data_q, out_data_d;
    logic [255:0]  wdata_s, head_s;
    logic          fire_s, pop_s, full_s, wr_s, drop_s;

    // Next-state for pointers, beat counter, level, flags and the registered beat.
    always_comb begin
        wdata_s     = (RELU_EN != 0) ? relu16(in_vector) : in_vector;
        fire_s      = out_valid_q && out_ready;
        pop_s       = fire_s && (beat_q == 2'd3);
        full_s      = (level_q == 4'(DEPTH));
        wr_s        = in_valid && (!full_s || pop_s);
        drop_s      = in_valid && full_s && !pop_s;
        wptr_d      = wr_s  ? ptr_inc(wptr_q) : wptr_q;
        rptr_d      = pop_s ? ptr_inc(rptr_q) : rptr_q;
        beat_d      = fire_s ? beat_q + 2'd1 : beat_q;
        level_d     = level_q + {3'b000, wr_s} - {3'b000, pop_s};
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        // The next head may be the slot being written this cycle; bypass the array then.
        if (wr_s && (wptr_q == rptr_d)) begin
            head_s = wdata_s;
        end else begin
            head_s = mem_q[rptr_d];
        end
        out_valid_d = (level_d != 4'd0);
        out_last_d  = out_valid_d && (beat_d == 2'd3);
        if (out_valid_d) begin
            out_data_d = beat_sel(head_s, beat_d);
        end else begin
            out_data_d = 64'h0;
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= {AW{1'b0}};
            rptr_q      <= {AW{1'b0}};
            beat_q      <= 2'd0;
            level_q     <= 4'd0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= 64'h0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            beat_q      <= beat_d;
            level_q     <= level_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    // Vector storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_q[wptr_q] <= wdata_s;
        end else begin
            mem_q[wptr_q] <= mem_q[wptr_q];
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;
    assign level     = level_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_acc_out_packer.sv
// Self-checking bench for acc_out_packer: queue-based reference model, directed corner
// sequences, a ReLU vector table and randomized traffic.
module tb_acc_out_packer;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, out_ready, ovf_clr;
    logic [255:0] in_vector;
    logic         out_valid, out_last, overflow;
    logic [63:0]  out_data;
    logic [3:0]   level;

    logic         r_in_valid, r_out_ready, r_ovf_clr;
    logic [255:0] r_in_vector;
    logic         r_out_valid, r_out_last, r_overflow;
    logic [63:0]  r_out_data;
    logic [3:0]   r_level;

    always #5 clk = ~clk;

    acc_out_packer #(.DEPTH(DEPTH), .RELU_EN(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_vector(in_vector),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .level(level), .overflow(overflow), .ovf_clr(ovf_clr)
    );

    acc_out_packer #(.DEPTH(DEPTH), .RELU_EN(1)) dut_r (
        .clk(clk), .rst_n(rst_n), .in_valid(r_in_valid), .in_vector(r_in_vector),
        .out_valid(r_out_valid), .out_ready(r_out_ready), .out_data(r_out_data),
        .out_last(r_out_last), .level(r_level), .overflow(r_overflow), .ovf_clr(r_ovf_clr)
    );

    typedef struct {
        logic [255:0] vin;
        logic [255:0] vexp;
    } relu_vec_t;

    relu_vec_t    rtab [3];
    int           n_vec = 0;
    int           n_err = 0;
    logic [255:0] mq [$];
    int           mbeat = 0;
    bit           movf = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [255:0] h;
        logic [63:0]  ed;
        bit           ev;
        ev = (mq.size() > 0);
        ed = 64'h0;
        if (ev) begin
            h  = mq[0];
            ed = h[64*mbeat +: 64];
        end
        chk("out_valid", 64'(out_valid), 64'(ev));
        chk("out_data",  out_data, ed);
        chk("out_last",  64'(out_last), 64'(ev && (mbeat == 3)));
        chk("level",     64'(level), 64'(mq.size()));
        chk("overflow",  64'(overflow), 64'(movf));
    endtask

    // Advance the model by one clock using the inputs currently driven, then compare.
    task automatic tick();
        bit handoff, pop, full, accept;
        handoff = (mq.size() > 0) && out_ready;
        pop     = handoff && (mbeat == 3);
        full    = (mq.size() == DEPTH);
        accept  = in_valid && (!full || pop);
        if (in_valid && !accept) movf = 1'b1;
        else if (ovf_clr)         movf = 1'b0;
        if (handoff) mbeat = (mbeat + 1) % 4;
        if (pop) void'(mq.pop_front());
        if (accept) mq.push_back(in_vector);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic drive(input bit v, input logic [255:0] d, input bit rdy, input bit clr);
        in_valid  = v;
        in_vector = d;
        out_ready = rdy;
        ovf_clr   = clr;
    endtask

    function automatic logic [255:0] lanes_from(input logic [15:0] base);
        logic [255:0] r;
        for (int k = 0; k < 16; k++) r[16*k +: 16] = base + 16'(k);
        return r;
    endfunction

    function automatic logic [255:0] rand_vec();
        logic [255:0] r;
        for (int w = 0; w < 8; w++) r[32*w +: 32] = $urandom();
        return r;
    endfunction

    initial begin
        for (int k = 0; k < 16; k++) begin
            rtab[0].vin[16*k +: 16]  = (k == 0) ? 16'h8000 : ((k % 2 == 0) ? 16'hC000 : 16'h4000);
            rtab[0].vexp[16*k +: 16] = (k % 2 == 1) ? 16'h4000 : 16'h0000;
            case (k % 4)
                0:       begin rtab[1].vin[16*k +: 16] = 16'h7FFF; rtab[1].vexp[16*k +: 16] = 16'h7FFF; end
                1:       begin rtab[1].vin[16*k +: 16] = 16'hFFFF; rtab[1].vexp[16*k +: 16] = 16'h0000; end
                2:       begin rtab[1].vin[16*k +: 16] = 16'hFE00; rtab[1].vexp[16*k +: 16] = 16'h0000; end
                default: begin rtab[1].vin[16*k +: 16] = 16'h0001; rtab[1].vexp[16*k +: 16] = 16'h0001; end
            endcase
            rtab[2].vin[16*k +: 16]  = 16'h3C00 + 16'(k);
            rtab[2].vexp[16*k +: 16] = 16'h3C00 + 16'(k);
        end

        rst_n = 1'b0;
        drive(1'b0, 256'h0, 1'b0, 1'b0);
        r_in_valid = 1'b0; r_in_vector = 256'h0; r_out_ready = 1'b1; r_ovf_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;
        tick();

        // Single vector, ready high: valid next cycle, four beats, level back to 0.
        drive(1'b1, lanes_from(16'h3C00), 1'b1, 1'b0);
        tick();
        chk("beat0_const", out_data, 64'h3C03_3C02_3C01_3C00);
        drive(1'b0, 256'h0, 1'b1, 1'b0);
        repeat (4) tick();
        chk("level_after_single", 64'(level), 64'd0);

        // Stall for 5 cycles during beat 1.
        drive(1'b1, lanes_from(16'h3C00), 1'b1, 1'b0);
        tick();
        drive(1'b0, 256'h0, 1'b1, 1'b0);
        tick();
        chk("beat1_const", out_data, 64'h3C07_3C06_3C05_3C04);
        drive(1'b0, 256'h0, 1'b0, 1'b0);
        repeat (5) tick();
        chk("beat1_held", out_data, 64'h3C07_3C06_3C05_3C04);
        drive(1'b0, 256'h0, 1'b1, 1'b0);
        repeat (3) tick();

        // Overflow: six writes with no consumer, drain, then clear.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, lanes_from(16'(16'h1000 * (i + 1))), 1'b0, 1'b0);
            tick();
            if (i == 3) chk("ovf_before_5th", 64'(overflow), 64'd0);
            if (i == 4) chk("ovf_after_5th", 64'(overflow), 64'd1);
        end
        chk("level_full", 64'(level), 64'd4);
        drive(1'b0, 256'h0, 1'b1, 1'b0);
        repeat (16) tick();
        drive(1'b0, 256'h0, 1'b1, 1'b1);
        tick();
        chk("ovf_cleared", 64'(overflow), 64'd0);

        // Full FIFO, write coincides with beat-3 handoff.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, rand_vec(), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 256'h0, 1'b1, 1'b0);
        repeat (3) tick();
        drive(1'b1, rand_vec(), 1'b1, 1'b0);
        tick();
        chk("full_pop_level", 64'(level), 64'd4);
        chk("full_pop_ovf", 64'(overflow), 64'd0);
        drive(1'b0, 256'h0, 1'b1, 1'b0);
        repeat (16) tick();

        // ReLU table on the RELU_EN=1 instance.
        for (int i = 0; i < 3; i++) begin
            r_in_valid  = 1'b1;
            r_in_vector = rtab[i].vin;
            @(posedge clk); #1;
            r_in_valid = 1'b0;
            for (int b = 0; b < 4; b++) begin
                chk("relu_valid", 64'(r_out_valid), 64'd1);
                chk("relu_data", r_out_data, rtab[i].vexp[64*b +: 64]);
                chk("relu_last", 64'(r_out_last), 64'(b == 3));
                @(posedge clk); #1;
            end
            chk("relu_level", 64'(r_level), 64'd0);
        end

        // Asynchronous reset mid beat 2 with three vectors stored.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, rand_vec(), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 256'h0, 1'b1, 1'b0);
        repeat (2) tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_data", out_data, 64'h0);
        chk("arst_last", 64'(out_last), 64'd0);
        chk("arst_level", 64'(level), 64'd0);
        mq.delete();
        mbeat = 0;
        movf  = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        drive(1'b1, lanes_from(16'h3C00), 1'b1, 1'b0);
        tick();
        chk("post_rst_beat0", out_data, 64'h3C03_3C02_3C01_3C00);
        drive(1'b0, 256'h0, 1'b1, 1'b0);
        repeat (4) tick();

        // Randomized traffic against the queue model.
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 99) < 30), rand_vec(),
                  ($urandom_range(0, 99) < 65), ($urandom_range(0, 99) < 5));
            tick();
        end
        for (int c = 0; c < 40; c++) begin
            drive(($urandom_range(0, 99) < 25), rand_vec(), 1'b1, 1'b0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
